// File: rtl/dig_out_pwm.sv
// rtl/dig_out_pwm.sv - three-channel 8-bit PWM with shared prescaler/counter and period-boundary duty shadows
// Optional build macro PWM_CENTER_ALIGNED_EN selects an up/down (center-aligned) counter.
module dig_out_pwm #(
    parameter int PRESC_DIV = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iEN,
    input  logic [7:0] iDUTYA,
    input  logic [7:0] iDUTYB,
    input  logic [7:0] iDUTYC,
    output logic       oPWMA,
    output logic       oPWMB,
    output logic       oPWMC,
    output logic       oPERIOD_END
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESC_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  shadow_a_q, shadow_a_d;
    logic [7:0]  shadow_b_q, shadow_b_d;
    logic [7:0]  shadow_c_q, shadow_c_d;
    logic        pwm_a_q, pwm_a_d;
    logic        pwm_b_q, pwm_b_d;
    logic        pwm_c_q, pwm_c_d;
    logic        period_end_q, period_end_d;
    logic        tick;
    logic        load;
`ifdef PWM_CENTER_ALIGNED_EN
    logic        dir_down_q, dir_down_d;
`endif

    always_comb begin
        tick         = iEN && (presc_q == PRESC_LAST);
        presc_d      = (!iEN || tick) ? 16'd0 : presc_q + 16'd1;
        cnt_d        = cnt_q;
        period_end_d = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        // Each end value (0 and 255) is held for a single tick before turning around.
        dir_down_d = dir_down_q;
        if (!iEN) begin
            cnt_d      = 8'd0;
            dir_down_d = 1'b0;
        end else if (tick) begin
            if (dir_down_q) begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    dir_down_d   = 1'b0;
                    period_end_d = 1'b1;
                end
            end else if (cnt_q == 8'hFF) begin
                cnt_d      = 8'hFE;
                dir_down_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
`else
        if (!iEN) begin
            cnt_d = 8'd0;
        end else if (tick) begin
            cnt_d        = cnt_q + 8'd1;
            period_end_d = (cnt_q == 8'hFF);
        end
`endif
        // Shadows are transparent while disabled so the first enabled period uses current duties.
        load       = !iEN || period_end_d;
        shadow_a_d = load ? iDUTYA : shadow_a_q;
        shadow_b_d = load ? iDUTYB : shadow_b_q;
        shadow_c_d = load ? iDUTYC : shadow_c_q;
        pwm_a_d    = iEN && (cnt_q < shadow_a_q);
        pwm_b_d    = iEN && (cnt_q < shadow_b_q);
        pwm_c_d    = iEN && (cnt_q < shadow_c_q);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            presc_q      <= 16'd0;
            cnt_q        <= 8'd0;
            shadow_a_q   <= 8'd0;
            shadow_b_q   <= 8'd0;
            shadow_c_q   <= 8'd0;
            pwm_a_q      <= 1'b0;
            pwm_b_q      <= 1'b0;
            pwm_c_q      <= 1'b0;
            period_end_q <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_down_q   <= 1'b0;
`endif
        end else begin
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            shadow_a_q   <= shadow_a_d;
            shadow_b_q   <= shadow_b_d;
            shadow_c_q   <= shadow_c_d;
            pwm_a_q      <= pwm_a_d;
            pwm_b_q      <= pwm_b_d;
            pwm_c_q      <= pwm_c_d;
            period_end_q <= period_end_d;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_down_q   <= dir_down_d;
`endif
        end
    end

    assign oPWMA       = pwm_a_q;
    assign oPWMB       = pwm_b_q;
    assign oPWMC       = pwm_c_q;
    assign oPERIOD_END = period_end_q;

endmodule
